// File: rtl/snn_frame_ctrl.sv
// snn_frame_ctrl: unpacks a bit-packed UART frame into the input RAM, runs the SNN core, and sends the digit as ASCII.
// Optional core watchdog: define SNN_TIMEOUT_EN.
module snn_frame_ctrl #(
   parameter int NUM_BITS    = 784,
   parameter int TIMEOUT_CYC = 65535
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_rdy,
   input  logic [7:0] rx_data,
   output logic       ram_we,
   output logic [9:0] ram_addr,
   output logic       ram_d,
   input  logic [9:0] core_addr,
   output logic       core_start,
   input  logic       core_done,
   input  logic [3:0] core_digit,
   input  logic       tx_rdy,
   output logic       tx_start,
   output logic [7:0] tx_data,
   output logic [3:0] digit,
   output logic       busy,
   output logic       ovr,
   output logic       err
);
   typedef enum logic [2:0] {IDLE, UNPACK, LOAD, START, WAIT_DONE, TX} state_t;
   localparam logic [9:0] LAST = 10'(NUM_BITS - 1);
   if (NUM_BITS % 8 != 0 || NUM_BITS > 1024 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_cfg
      $error("snn_frame_ctrl: invalid NUM_BITS or TIMEOUT_CYC");
   end
   state_t     state_q, state_d;
   logic [7:0] shift_q, shift_d, hold_q, hold_d, tx_data_q, tx_data_d;
   logic [9:0] cnt_q, cnt_d;
   logic [3:0] digit_q, digit_d;
   logic       hold_full_q, hold_full_d, ovr_q, ovr_d, tmo;
`ifdef SNN_TIMEOUT_EN
   logic [15:0] tmo_q;
   logic        err_q;
   assign tmo = (state_q == WAIT_DONE) && (tmo_q == 16'(TIMEOUT_CYC));
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         tmo_q <= (state_q == WAIT_DONE) ? tmo_q + 16'd1 : '0;
         err_q <= (state_q == IDLE && rx_rdy) ? 1'b0 : err_q | (tmo & ~core_done);
      end
   end
   assign err = err_q;
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;
      digit_d     = digit_q;
      tx_data_d   = tx_data_q;
      ovr_d       = ovr_q | (rx_rdy & (state_q == START || state_q == WAIT_DONE || state_q == TX));
      ram_we      = 1'b0;
      ram_d       = 1'b0;
      ram_addr    = cnt_q;
      core_start  = 1'b0;
      tx_start    = 1'b0;
      case (state_q)
         IDLE: if (rx_rdy) begin
            shift_d = rx_data;
            ovr_d   = 1'b0;
            state_d = UNPACK;
         end
         UNPACK: begin
            ram_we  = 1'b1;
            ram_d   = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            cnt_d   = cnt_q + 10'd1;
            if (cnt_q[2:0] != 3'd7) begin
               if (rx_rdy && hold_full_q) ovr_d = 1'b1;
               else if (rx_rdy) begin
                  hold_d      = rx_data;
                  hold_full_d = 1'b1;
               end
            end else if (cnt_q == LAST) begin
               // a byte still pending past the frame end has nowhere to go
               ovr_d       = ovr_q | hold_full_q | rx_rdy;
               hold_full_d = 1'b0;
               state_d     = START;
            end else if (hold_full_q) begin
               shift_d     = hold_q;
               hold_d      = rx_data;
               hold_full_d = rx_rdy;
            end else if (rx_rdy) shift_d = rx_data;
            else state_d = LOAD;
         end
         LOAD: if (rx_rdy) begin
            shift_d = rx_data;
            state_d = UNPACK;
         end
         START: begin
            core_start = 1'b1;
            state_d    = WAIT_DONE;
         end
         WAIT_DONE: begin
            ram_addr = core_addr;
            if (core_done) begin
               digit_d = core_digit;
               state_d = TX;
            end else if (tmo) begin
               digit_d = 4'hF;
               state_d = TX;
            end
         end
         TX: if (tx_rdy) begin
            tx_start  = 1'b1;
            tx_data_d = 8'h30 + {4'h0, digit_q};
            cnt_d     = '0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         digit_q     <= '0;
         tx_data_q   <= '0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         digit_q     <= digit_d;
         tx_data_q   <= tx_data_d;
         ovr_q       <= ovr_d;
      end
   end
   assign digit   = digit_q;
   assign tx_data = tx_data_q;
   assign ovr     = ovr_q;
   assign busy    = state_q != IDLE;
endmodule

// File: tb/tb_snn_frame_ctrl.sv
// tb_snn_frame_ctrl: directed bench for snn_frame_ctrl; RAM writes, start and tx pulses are logged on the falling edge.
module tb_snn_frame_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0, rx_rdy = 1'b0, core_done = 1'b0, tx_rdy = 1'b0;
   logic [7:0] rx_data = '0;
   logic [9:0] core_addr = '0;
   logic [3:0] core_digit = '0;
   logic       ram_we, ram_d, core_start, tx_start, busy, ovr, err;
   logic [9:0] ram_addr;
   logic [7:0] tx_data;
   logic [3:0] digit;
   int nvec = 0, nfail = 0, cyc = 0, nwr = 0, nst = 0, ntx = 0;
   int wa[4096];
   int wc[4096];
   bit wd[4096];
   int st_cyc[16];
   bit expb[784];

   snn_frame_ctrl #(.NUM_BITS(784), .TIMEOUT_CYC(100)) dut (
      .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_d(ram_d), .core_addr(core_addr),
      .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
      .tx_rdy(tx_rdy), .tx_start(tx_start), .tx_data(tx_data), .digit(digit),
      .busy(busy), .ovr(ovr), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      if (ram_we && nwr < 4096) begin
         wa[nwr] = int'(ram_addr);
         wd[nwr] = ram_d;
         wc[nwr] = cyc;
         nwr++;
      end
      if (core_start) begin
         if (nst < 16) st_cyc[nst] = cyc;
         nst++;
      end
      if (tx_start) ntx++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 rx_rdy = 1'b1;
      rx_data = b;
      @(posedge clk);
      #1 rx_rdy = 1'b0;
   endtask

   task automatic send_frame(input int mode, input int gap);
      logic [7:0] b;
      for (int i = 0; i < 98; i++) begin
         b = (mode == 0) ? 8'hA5 : 8'(i * 29 + 3);
         for (int k = 0; k < 8; k++) expb[i*8+k] = b[k];
         send_byte(b);
         cycles(gap);
      end
   endtask

   task automatic check_frame(input int base, input string tag);
      int bad = 0;
      for (int i = 0; i < 784; i++)
         if (wa[base+i] != i || wd[base+i] != expb[i]) bad++;
      chk({tag, "_writes"}, nwr - base, 784);
      chk({tag, "_data"}, bad, 0);
   endtask

   initial begin
      int b, s, bad;
      cycles(3);
      chk("rst_busy", busy, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_start", core_start, 0);
      chk("rst_txstart", tx_start, 0);
      chk("rst_flags", {ovr, err, digit}, 0);
      rst_n = 1'b1;
      cycles(2);
      // frame of 0xA5 with long gaps
      b = nwr;
      send_frame(0, 200);
      check_frame(b, "f1");
      chk("f1_starts", nst, 1);
      chk("f1_start_lat", st_cyc[0], wc[b+783] + 1);
      chk("f1_busy", busy, 1);
      core_addr = 10'h2A7;
      #1;
      chk("wait_addr_mux", ram_addr, 10'h2A7);
      chk("wait_we", ram_we, 0);
      // result and transmit
      tx_rdy = 1'b1;
      @(posedge clk);
      #1 core_done = 1'b1;
      core_digit = 4'd7;
      @(posedge clk);
      #1 core_done = 1'b0;
      core_digit = 4'd0;
      chk("digit7", digit, 7);
      chk("tx_pulse", tx_start, 1);
      cycles(5);
      chk("tx_data7", tx_data, 8'h37);
      chk("tx_once", ntx, 1);
      chk("idle_busy", busy, 0);
      // holding register: second byte buffered
      b = nwr;
      send_byte(8'h0F);
      send_byte(8'hF0);
      cycles(20);
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (wa[b+i] != i || wd[b+i] != ((i < 8) ? (i < 4) : (i >= 12))) bad++;
      chk("hold_writes", nwr - b, 16);
      chk("hold_data", bad, 0);
      chk("hold_ovr", ovr, 0);
      // third byte before drain is dropped
      b = nwr;
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h81);
      cycles(20);
      bad = 0;
      for (int i = 0; i < 16; i++)
         if (wa[b+i] != 16 + i || wd[b+i] != (i >= 8)) bad++;
      chk("ovr_set", ovr, 1);
      chk("ovr_writes", nwr - b, 16);
      chk("ovr_data", bad, 0);
      // reset after 40 bytes
      for (int i = 0; i < 36; i++) begin
         send_byte(8'h55);
         cycles(12);
      end
      rst_n = 1'b0;
      cycles(3);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ovr", ovr, 0);
      chk("mid_rst_out", {digit, tx_data, ram_addr}, 0);
      rst_n = 1'b1;
      cycles(2);
      b = nwr;
      s = nst;
      send_frame(1, 12);
      cycles(20);
      check_frame(b, "f2");
      chk("f2_starts", nst - s, 1);
      chk("f2_start_lat", st_cyc[s], wc[b+783] + 1);
      // transmitter busy for 500 cycles
      tx_rdy = 1'b0;
      s = ntx;
      @(posedge clk);
      #1 core_done = 1'b1;
      core_digit = 4'd3;
      @(posedge clk);
      #1 core_done = 1'b0;
      send_byte(8'h11);
      cycles(500);
      chk("txwait_none", ntx - s, 0);
      chk("txwait_busy", busy, 1);
      chk("txwait_digit", digit, 3);
      chk("late_byte_ovr", ovr, 1);
      tx_rdy = 1'b1;
      cycles(10);
      chk("txwait_one", ntx - s, 1);
      chk("tx_data3", tx_data, 8'h33);
      chk("txwait_idle", busy, 0);
      send_byte(8'h00);
      chk("first_byte_clr_ovr", ovr, 0);
`ifdef SNN_TIMEOUT_EN
      for (int i = 0; i < 97; i++) begin
         send_byte(8'h00);
         cycles(12);
      end
      cycles(300);
      chk("tmo_err", err, 1);
      chk("tmo_digit", digit, 4'hF);
      chk("tmo_tx_data", tx_data, 8'h3F);
      chk("tmo_idle", busy, 0);
      send_byte(8'h00);
      chk("tmo_err_clr", err, 0);
`else
      chk("err_tied", err, 0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
